// File: rtl/mem_test_sequencer_pkg.sv
// Shared definitions for the memory checker: test mode encodings (as seen
// on the CSR mode field), the decoded test mode type, and the sequencer
// state type.
// Ports: none (package).
package mem_checker_pkg;

  // Raw CSR encodings of the mode field.
  localparam logic [1:0] MODE_WR_ONLY = 2'b00;
  localparam logic [1:0] MODE_RD_ONLY = 2'b01;
  localparam logic [1:0] MODE_WR_RD   = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    WR_ONLY = 2'b00,
    RD_ONLY = 2'b01,
    WR_RD   = 2'b10
  } test_mode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_WAIT_RD = 3'd3,
    S_DONE    = 3'd4
  } seq_state_t;

  // The reserved encoding runs as write-only.
  function automatic test_mode_t decode_mode(input logic [1:0] raw);
    test_mode_t m;
    case (raw)
      MODE_RD_ONLY: m = RD_ONLY;
      MODE_WR_RD:   m = WR_RD;
      MODE_WR_ONLY: m = WR_ONLY;
      MODE_RSVD:    m = WR_ONLY;
      default:      m = WR_ONLY;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_test_sequencer_if.sv
// Avalon-MM master bus used by the sequencer to reach the memory under test.
// Signals: address, write, writedata, read, burstcount (master -> slave);
//          waitrequest, readdatavalid (slave -> master).
// Modports: master (sequencer side), slave (memory / bench side).
interface mem_test_sequencer_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 4
) ();
  logic [ADDR_W-1:0]  address;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic               read;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;
  logic               readdatavalid;

  modport master (
    output address, write, writedata, read, burstcount,
    input  waitrequest, readdatavalid
  );

  modport slave (
    input  address, write, writedata, read, burstcount,
    output waitrequest, readdatavalid
  );
endinterface

// File: rtl/mem_test_sequencer.sv
// Sequencing engine of the memory checker. Runs test_count write, read or
// write-then-read bursts from start_addr over an Avalon-MM master port and
// pulses done_o when finished.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               start pulse (sampled only while idle)
//   mode_i, burstcount_i, test_count_i, start_addr_i  test configuration
//   wdata_i / wdata_next_o  pattern word in / advance pattern generator
//   amm                   Avalon-MM master bus (interface, master modport)
//   busy_o, done_o        status; done_o is a one-cycle pulse
//   protocol_err_o        sticky flag for readdatavalid outside WAIT_RD
module mem_test_sequencer
  import mem_checker_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [BURST_W-1:0] burstcount_i,
  input  logic [CNT_W-1:0]   test_count_i,
  input  logic [ADDR_W-1:0]  start_addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic               wdata_next_o,
  mem_test_sequencer_if.master amm,
  output logic               busy_o,
  output logic               done_o,
  output logic               protocol_err_o
);

  seq_state_t         state_reg, state_next;
  test_mode_t         mode_reg;
  logic [BURST_W-1:0] burst_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [CNT_W-1:0]   trans_cnt_reg;
  logic [BURST_W-1:0] beat_cnt_reg;
  logic               perr_reg;

  logic               start_ok;
  logic [BURST_W-1:0] start_burst;
  logic               wr_accept;
  logic               last_wr;
  logic               rd_accept;
  logic               rd_beat;
  logic               last_rd_beat;
  logic               txn_end;
  logic               last_txn;
  seq_state_t         txn_next_state;

  assign start_ok    = (state_reg == S_IDLE) && start_i;
  assign start_burst = (burstcount_i == '0) ? BURST_W'(1) : burstcount_i;

  assign wr_accept    = (state_reg == S_WRITE) && !amm.waitrequest;
  assign last_wr      = wr_accept && (beat_cnt_reg == burst_reg - BURST_W'(1));
  assign rd_accept    = (state_reg == S_READ) && !amm.waitrequest;
  assign rd_beat      = (state_reg == S_WAIT_RD) && amm.readdatavalid;
  assign last_rd_beat = rd_beat && (beat_cnt_reg == burst_reg - BURST_W'(1));

  // A write-then-read transaction ends on its read data, not on its writes.
  assign txn_end  = (last_wr && (mode_reg != WR_RD)) || last_rd_beat;
  assign last_txn = (trans_cnt_reg == CNT_W'(1));

  assign txn_next_state = last_txn ? S_DONE :
                          (mode_reg == RD_ONLY) ? S_READ : S_WRITE;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          if (test_count_i == '0)
            state_next = S_DONE;
          else if (decode_mode(mode_i) == RD_ONLY)
            state_next = S_READ;
          else
            state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (txn_end)
          state_next = txn_next_state;
        else if (last_wr)
          state_next = S_READ;   // write-then-read: read back the same burst
      end
      S_READ: begin
        if (rd_accept)
          state_next = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (txn_end)
          state_next = txn_next_state;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_IDLE;
      mode_reg      <= WR_ONLY;
      burst_reg     <= '0;
      addr_reg      <= '0;
      trans_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
      perr_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (start_ok) begin
        mode_reg      <= decode_mode(mode_i);
        burst_reg     <= start_burst;
        addr_reg      <= start_addr_i;
        trans_cnt_reg <= test_count_i;
        beat_cnt_reg  <= '0;
      end else begin
        // Beat counter is shared by the write burst and the read data phase.
        if (last_wr || rd_accept || last_rd_beat)
          beat_cnt_reg <= '0;
        else if (wr_accept || rd_beat)
          beat_cnt_reg <= beat_cnt_reg + BURST_W'(1);

        if (txn_end) begin
          trans_cnt_reg <= trans_cnt_reg - CNT_W'(1);
          addr_reg      <= addr_reg + ADDR_W'(burst_reg);
        end
      end

      // A fresh start clears the flag; otherwise stray read data sets it.
      if (start_ok)
        perr_reg <= 1'b0;
      else if (amm.readdatavalid && (state_reg != S_WAIT_RD))
        perr_reg <= 1'b1;
    end
  end

  assign amm.address    = addr_reg;
  assign amm.burstcount = burst_reg;
  assign amm.write      = (state_reg == S_WRITE);
  assign amm.read       = (state_reg == S_READ);
  assign amm.writedata  = wdata_i;

  assign wdata_next_o   = wr_accept;
  assign busy_o         = (state_reg != S_IDLE);
  assign done_o         = (state_reg == S_DONE);
  assign protocol_err_o = perr_reg;

endmodule
